// File: rtl/immgen_pipe.sv
// Registered ID-stage immediate generator with a 2-entry skid buffer and tag sideband.
// ImmSel encoding: 0=I 1=S 2=SB 3=UJ 4=U 5=Z 6=SH; 7 is unsupported.
module immgen_pipe #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 8,
  parameter bit ENABLE_EXT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ImmSel,
  input  logic [31:7]      instr,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [2:0] {
    IMMGEN_I  = 3'd0,
    IMMGEN_S  = 3'd1,
    IMMGEN_SB = 3'd2,
    IMMGEN_UJ = 3'd3,
    IMMGEN_U  = 3'd4,
    IMMGEN_Z  = 3'd5,
    IMMGEN_SH = 3'd6
  } immgen_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("immgen_pipe: XLEN must be 32 or 64");
  end

  immgen_t             w_sel;
  logic [31:0]         w_raw;
  logic                w_sext;
  logic                w_ill;
  logic [XLEN-1:0]     w_imm;
  logic                w_push;
  logic                w_pop;

  occ_t                r_occ;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [XLEN-1:0]     r_head_imm;
  logic [TAG_W-1:0]    r_head_tag;
  logic                r_head_ill;
  logic [XLEN-1:0]     r_skid_imm;
  logic [TAG_W-1:0]    r_skid_tag;
  logic                r_skid_ill;

  assign w_sel = immgen_t'(ImmSel);

  // Every signed format is first built as a 32-bit sign-extended value, then widened once.
  always_comb begin
    w_raw  = '0;
    w_sext = 1'b0;
    w_ill  = 1'b0;
    w_imm  = '0;
    case (w_sel)
      IMMGEN_I: begin
        w_raw  = {{20{instr[31]}}, instr[31:20]};
        w_sext = 1'b1;
      end
      IMMGEN_S: begin
        w_raw  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        w_sext = 1'b1;
      end
      IMMGEN_SB: begin
        w_raw  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        w_sext = 1'b1;
      end
      IMMGEN_UJ: begin
        w_raw  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        w_sext = 1'b1;
      end
      IMMGEN_U: begin
        w_raw  = {instr[31:12], 12'b0};
        w_sext = 1'b1;
      end
      IMMGEN_Z: begin
        if (ENABLE_EXT) w_raw = {27'b0, instr[19:15]};
        else            w_ill = 1'b1;
      end
      IMMGEN_SH: begin
        if (!ENABLE_EXT)    w_ill = 1'b1;
        else if (XLEN == 64) w_raw = {26'b0, instr[25:20]};
        else                 w_raw = {27'b0, instr[24:20]};
      end
      default: w_ill = 1'b1;
    endcase
    if (w_sext) w_imm = XLEN'($signed(w_raw));
    else        w_imm = XLEN'(w_raw);
  end

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  // Head register drives the outputs directly; the skid register only fills when the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ       <= OCC_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head_imm  <= '0;
      r_head_tag  <= '0;
      r_head_ill  <= 1'b0;
      r_skid_imm  <= '0;
      r_skid_tag  <= '0;
      r_skid_ill  <= 1'b0;
    end else if (flush) begin
      r_occ       <= OCC_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_push) begin
            r_head_imm  <= w_imm;
            r_head_tag  <= in_tag;
            r_head_ill  <= w_ill;
            r_occ       <= OCC_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            r_head_imm <= w_imm;
            r_head_tag <= in_tag;
            r_head_ill <= w_ill;
          end else if (w_push) begin
            r_skid_imm <= w_imm;
            r_skid_tag <= in_tag;
            r_skid_ill <= w_ill;
            r_occ      <= OCC_FULL;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_occ       <= OCC_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head_imm <= r_skid_imm;
            r_head_tag <= r_skid_tag;
            r_head_ill <= r_skid_ill;
            r_occ      <= OCC_ONE;
            r_in_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_head_imm;
  assign out_tag     = r_head_tag;
  assign out_illegal = r_head_ill;

endmodule

// File: tb/tb_immgen_pipe.sv
// Scoreboard bench for immgen_pipe: three configurations (32/ext, 64/ext, 32/no-ext) share one stimulus stream.
module tb_immgen_pipe;

  typedef enum logic [2:0] {
    SEL_I = 3'd0, SEL_S = 3'd1, SEL_SB = 3'd2, SEL_UJ = 3'd3,
    SEL_U = 3'd4, SEL_Z = 3'd5, SEL_SH = 3'd6, SEL_BAD = 3'd7
  } sel_t;

  typedef struct packed {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [2:0]  sel;
  logic [31:0] ins;
  logic [7:0]  tag;

  logic        a_ir, a_ov, a_ill, b_ir, b_ov, b_ill, c_ir, c_ov, c_ill;
  logic [31:0] a_imm, c_imm;
  logic [63:0] b_imm;
  logic [7:0]  a_tag, b_tag, c_tag;

  exp_t        q[3][$];
  int          checks   = 0;
  int          failures = 0;
  bit          use_k    = 1'b0;
  logic [63:0] k32, k64;

  always #5 clk = ~clk;

  immgen_pipe #(.XLEN(32), .TAG_W(8), .ENABLE_EXT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir), .ImmSel(sel),
    .instr(ins[31:7]), .in_tag(tag), .flush(flush), .out_valid(a_ov), .out_ready(out_ready),
    .out_imm(a_imm), .out_tag(a_tag), .out_illegal(a_ill));

  immgen_pipe #(.XLEN(64), .TAG_W(8), .ENABLE_EXT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ir), .ImmSel(sel),
    .instr(ins[31:7]), .in_tag(tag), .flush(flush), .out_valid(b_ov), .out_ready(out_ready),
    .out_imm(b_imm), .out_tag(b_tag), .out_illegal(b_ill));

  immgen_pipe #(.XLEN(32), .TAG_W(8), .ENABLE_EXT(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_ir), .ImmSel(sel),
    .instr(ins[31:7]), .in_tag(tag), .flush(flush), .out_valid(c_ov), .out_ready(out_ready),
    .out_imm(c_imm), .out_tag(c_tag), .out_illegal(c_ill));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input int xlen, input bit ext, input logic [2:0] s,
                                 input logic [31:0] i, input logic [7:0] t);
    exp_t        e;
    logic [63:0] v;
    logic        il;
    v  = '0;
    il = 1'b0;
    case (s)
      3'd0: v = {{52{i[31]}}, i[31:20]};
      3'd1: v = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: v = {{32{i[31]}}, i[31:12], 12'b0};
      3'd5: if (ext) v = {59'b0, i[19:15]}; else il = 1'b1;
      3'd6: if (!ext) il = 1'b1;
            else if (xlen == 64) v = {58'b0, i[25:20]};
            else v = {59'b0, i[24:20]};
      default: il = 1'b1;
    endcase
    if (il) v = '0;
    if (xlen == 32) v[63:32] = '0;
    e.imm = v;
    e.tag = t;
    e.ill = il;
    return e;
  endfunction

  // One scoreboard step per DUT, evaluated at the falling edge before the next rising edge.
  task automatic sb(input int idx, input string nm, input logic ov, input logic ir,
                    input logic [63:0] oimm, input logic [7:0] otag, input logic oill);
    bit   rdy;
    exp_t e;
    rdy = (q[idx].size() < 2);
    chk({nm, ".in_ready"}, {63'b0, ir}, {63'b0, rdy});
    chk({nm, ".out_valid"}, {63'b0, ov}, {63'b0, (q[idx].size() != 0)});
    if (q[idx].size() != 0) begin
      e = q[idx][0];
      chk({nm, ".out_imm"}, oimm, e.imm);
      chk({nm, ".out_tag"}, {56'b0, otag}, {56'b0, e.tag});
      chk({nm, ".out_illegal"}, {63'b0, oill}, {63'b0, e.ill});
      if (out_ready) void'(q[idx].pop_front());
    end
    if (flush) q[idx].delete();
    else if (in_valid && rdy) begin
      e = model((idx == 1) ? 64 : 32, (idx != 2), sel, ins, tag);
      if (use_k && idx != 2) begin
        e.imm = (idx == 1) ? k64 : k32;
        e.ill = 1'b0;
      end
      q[idx].push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb(0, "x32", a_ov, a_ir, {32'b0, a_imm}, a_tag, a_ill);
    sb(1, "x64", b_ov, b_ir, b_imm, b_tag, b_ill);
    sb(2, "x32noext", c_ov, c_ir, {32'b0, c_imm}, c_tag, c_ill);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s, input logic [31:0] i, input logic [7:0] t,
                      input bit uk, input logic [63:0] e32, input logic [63:0] e64);
    in_valid = 1'b1;
    sel      = s;
    ins      = i;
    tag      = t;
    use_k    = uk;
    k32      = e32;
    k64      = e64;
    tick();
    use_k    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    sel = SEL_I; ins = '0; tag = '0; k32 = '0; k64 = '0;
    #12;
    chk("rst.out_valid", {63'b0, b_ov}, 64'd0);
    chk("rst.in_ready", {63'b0, b_ir}, 64'd1);
    chk("rst.out_imm", b_imm, 64'd0);
    chk("rst.out_tag", {56'b0, b_tag}, 64'd0);
    chk("rst.out_illegal", {63'b0, b_ill}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer vectors, back-to-back with out_ready high
    send(SEL_I,  32'hFFF00093, 8'h11, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    in_valid = 1'b0; tick();
    send(SEL_SB, 32'hFE000EE3, 8'h21, 1'b1, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    send(SEL_U,  32'h123450B7, 8'h22, 1'b1, 64'h12345000, 64'h0000000012345000);
    send(SEL_Z,  32'h000F8073, 8'h23, 1'b1, 64'h1F,       64'h1F);
    send(SEL_SH, 32'h03F00013, 8'h24, 1'b1, 64'h1F,       64'h3F);
    send(SEL_U,  32'h800000B7, 8'h25, 1'b1, 64'h80000000, 64'hFFFFFFFF80000000);
    send(SEL_BAD, 32'hFFFFFFFF, 8'h26, 1'b0, '0, '0);
    send(SEL_S,  32'hFE0000A3, 8'h27, 1'b0, '0, '0);
    send(SEL_UJ, 32'h8000006F, 8'h28, 1'b0, '0, '0);
    in_valid = 1'b0; tick(); tick();

    for (int n = 0; n < 60; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      ins       = $urandom;
      tag       = 8'(n);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    // Backpressure: third push must be refused, head frozen until out_ready rises
    out_ready = 1'b0;
    send(SEL_I, 32'h7FF00013, 8'hA1, 1'b0, '0, '0);
    send(SEL_S, 32'h80000023, 8'hA2, 1'b0, '0, '0);
    send(SEL_U, 32'hABCDE037, 8'hA3, 1'b0, '0, '0);
    in_valid = 1'b0; tick();
    out_ready = 1'b1;
    tick(); tick(); tick();

    // Flush while full with a simultaneous push
    out_ready = 1'b0;
    send(SEL_I, 32'h00100013, 8'hB1, 1'b0, '0, '0);
    send(SEL_I, 32'h00200013, 8'hB2, 1'b0, '0, '0);
    flush = 1'b1; in_valid = 1'b1; sel = SEL_I; ins = 32'h00300013; tag = 8'hB3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();

    // Flush with a simultaneous pop at count=1
    send(SEL_SB, 32'h00000463, 8'hC1, 1'b0, '0, '0);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    // Asynchronous reset with one entry buffered
    out_ready = 1'b0;
    send(SEL_I, 32'h12300013, 8'hD1, 1'b0, '0, '0);
    in_valid = 1'b0;
    #2;
    chk("prerst.out_valid", {63'b0, b_ov}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.x32.out_valid", {63'b0, a_ov}, 64'd0);
    chk("arst.x64.out_valid", {63'b0, b_ov}, 64'd0);
    chk("arst.x64.in_ready", {63'b0, b_ir}, 64'd1);
    chk("arst.x64.out_imm", b_imm, 64'd0);
    chk("arst.x32noext.in_ready", {63'b0, c_ir}, 64'd1);
    for (int k = 0; k < 3; k++) q[k].delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(SEL_Z, 32'h00050073, 8'hE1, 1'b0, '0, '0);
    in_valid = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
